fb_port_arbiter: RTL

//  Shares one single-port synchronous frame-buffer RAM between the VGA pixel reader (hard real-time)
//  and the edge-detection result writer (valid/ready). Display reads have absolute priority; writes

---
 rtl/fb_arb_pkg.sv | 26 ++
 rtl/fb_wr_fifo.sv | 54 +++++
 rtl/fb_port_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared constants, state encoding and helpers for the frame-buffer port arbiter
package fb_arb_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 8;
  localparam int STAT_W    = 20;

  // Cycles from a display request to disp_valid
  localparam int DISP_LAT = 2;

  // State encoding doubles as the RAM strobe pair: bit0 = ram_en, bit1 = ram_we
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_DISP  = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b11;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } wrEntry_t;

  // Saturating event counter step
  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] cnt, input logic ev);
    return (ev && cnt != '1) ? cnt + STAT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous write-queue FIFO with registered not-full flag
module fb_wr_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr, rdPtr, used, usedNext;
  logic             notFull, pushOk, popOk;

  assign used    = wrPtr - rdPtr;
  assign empty   = (used == '0);
  assign ready   = notFull;
  assign pushOk  = push & notFull;
  assign popOk   = pop & !empty;
  assign popData = mem[rdPtr[AW-1:0]];

  // Occupancy after this cycle's push/pop, used to precompute the full flag
  always_comb begin
    usedNext = used + PW'(pushOk) - PW'(popOk);
  end

  // Pointers wrap naturally; ready is held low while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      notFull <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (popOk)  rdPtr <= rdPtr + PW'(1);
      notFull <= (usedNext != DEPTH_P);
    end
  end

  // Entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer port arbiter: display reads pre-empt queued writes; FB_ARB_STATS_EN adds per-frame statistics
import fb_arb_pkg::*;

module fb_port_arbiter #(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int WBUF_DEPTH = 4,
  parameter int STARVE_MAX = 800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              starve_err
`ifdef FB_ARB_STATS_EN
  ,
  input  logic              frame_start,
  output logic [STAT_W-1:0] stat_rd,
  output logic [STAT_W-1:0] stat_wr,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] STARVE_PRE = CNT_W'(STARVE_MAX - 1);

  logic                     fifoEmpty, fifoReady, popEn, starveInc;
  logic [ADDR_W+DATA_W-1:0] headEntry;
  logic [ADDR_W-1:0]        headAddr;
  logic [DATA_W-1:0]        headData;
  logic [1:0]               state, nextState;
  logic [DISP_LAT-1:0]      rdPipe;
  logic [CNT_W-1:0]         starveCnt;

  // Writes only use cycles the display leaves free
  assign popEn     = !disp_req && !fifoEmpty;
  assign starveInc = disp_req && !fifoEmpty;
  assign {headAddr, headData} = headEntry;
  assign wr_ready  = fifoReady;

  fb_wr_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(WBUF_DEPTH)
  ) uWrFifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_valid),
    .pushData({wr_addr, wr_data}),
    .pop     (popEn),
    .popData (headEntry),
    .empty   (fifoEmpty),
    .ready   (fifoReady)
  );

  // Grant decision for this cycle; the registered state is the RAM command
  always_comb begin
    nextState = S_IDLE;
    if (disp_req)        nextState = S_DISP;
    else if (!fifoEmpty) nextState = S_DRAIN;
  end

  assign ram_en = state[0];
  assign ram_we = state[1];

  // Register the granted command toward the RAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state <= nextState;
      if (disp_req) begin
        ram_addr <= disp_addr;
      end else if (popEn) begin
        ram_addr  <= headAddr;
        ram_wdata <= headData;
      end
    end
  end

  // Track display reads through the RAM so data is flagged at fixed latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdPipe <= '0;
    else      rdPipe <= {rdPipe[DISP_LAT-2:0], disp_req};
  end

  assign disp_valid = rdPipe[DISP_LAT-1];
  assign disp_data  = disp_valid ? ram_rdata : '0;

  // Count cycles a queued write is blocked by display traffic; error is sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCnt  <= '0;
      starve_err <= 1'b0;
    end else begin
      if (popEn)                                        starveCnt <= '0;
      else if (starveInc && starveCnt != STARVE_LIM)    starveCnt <= starveCnt + CNT_W'(1);
      if (starveInc && starveCnt >= STARVE_PRE)         starve_err <= 1'b1;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [STAT_W-1:0] rdCnt, wrCnt, stallCnt;
  logic              stallEv;

  assign stallEv = wr_valid && !fifoReady;

  // Per-frame counters; frame_start publishes them and this cycle opens the next frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdCnt      <= '0;
      wrCnt      <= '0;
      stallCnt   <= '0;
      stat_rd    <= '0;
      stat_wr    <= '0;
      stat_stall <= '0;
    end else if (frame_start) begin
      stat_rd    <= rdCnt;
      stat_wr    <= wrCnt;
      stat_stall <= stallCnt;
      rdCnt      <= STAT_W'(disp_req);
      wrCnt      <= STAT_W'(popEn);
      stallCnt   <= STAT_W'(stallEv);
    end else begin
      rdCnt    <= satInc(rdCnt, disp_req);
      wrCnt    <= satInc(wrCnt, popEn);
      stallCnt <= satInc(stallCnt, stallEv);
    end
  end
`endif

endmodule
